// File: rtl/logicnets_asm_pkg.sv
// Shared widths and types for the LogicNets input assembler.
// The counter-width helper keeps a legal width even for single-feature configurations.
package logicnets_asm_pkg;

  localparam int FEAT_BITS = 2;
  localparam int NUM_FEAT  = 4;
  localparam int VEC_W     = NUM_FEAT * FEAT_BITS;

  function automatic int asm_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W = asm_cnt_w(NUM_FEAT);

  typedef logic [FEAT_BITS-1:0] feat_t;
  typedef logic [VEC_W-1:0]     vec_t;

endpackage

// File: rtl/logicnets_vec_reg.sv
// Registered valid/ready holding slot: loads in_data one edge after xfer and holds it stable under backpressure.
// xfer is combinational from out_ready, so a drained slot reloads in the same cycle with no bubble.
module logicnets_vec_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         xfer,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign xfer = in_valid && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/logicnets_input_assembler.sv
// Collects serial features into a packed vector for LogicNets layer 0; last beat to m_valid in two edges,
// s_ready drops only when both slots are full. Define LOGICNETS_ASM_ERRCNT_EN to add a saturating err_count output.
module logicnets_input_assembler #(
  parameter int FEAT_BITS = logicnets_asm_pkg::FEAT_BITS,
  parameter int NUM_FEAT  = logicnets_asm_pkg::NUM_FEAT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [FEAT_BITS-1:0]          s_data,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [NUM_FEAT*FEAT_BITS-1:0] m_data,
`ifdef LOGICNETS_ASM_ERRCNT_EN
  output logic [15:0]                   err_count,
`endif
  output logic                          frame_err
);
  import logicnets_asm_pkg::*;

  localparam int VEC_W = NUM_FEAT * FEAT_BITS;
  localparam int CNT_W = asm_cnt_w(NUM_FEAT);

  if (NUM_FEAT < 2) begin : g_num_feat_chk
    $error("logicnets_input_assembler: NUM_FEAT must be >= 2");
  end

  logic [VEC_W-1:0] col;
  logic [CNT_W-1:0] cnt;
  logic             col_full;
  logic             xfer;
  logic             acc;
  logic             last_slot;

  assign s_ready   = !col_full || xfer;
  assign acc       = s_valid && s_ready;
  assign last_slot = (cnt == CNT_W'(NUM_FEAT - 1));

  // An early s_last drops the partial vector; a missing one still completes it. Both flag a framing error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      cnt       <= '0;
      col_full  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= acc && (s_last != last_slot);
      if (xfer) begin
        col_full <= 1'b0;
      end
      if (acc) begin
        col[cnt*FEAT_BITS +: FEAT_BITS] <= s_data;
        if (last_slot) begin
          cnt      <= '0;
          col_full <= 1'b1;
        end else if (s_last) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  logicnets_vec_reg #(
    .W(VEC_W)
  ) u_vec_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (col_full),
    .in_data  (col),
    .xfer     (xfer),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data (m_data)
  );

`ifdef LOGICNETS_ASM_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (frame_err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/logicnets_input_assembler.md
Name: logicnets_input_assembler

Overview:
Upstream feeder for the first LUT layer of a LogicNets network. Accepts quantized input features serially, one per beat, over a valid/ready stream. Assembles them into the packed NUM_FEAT*FEAT_BITS input vector and presents it on a registered valid/ready output that drives the M0 bus of layer 0. Double-buffered, so collection of vector n+1 overlaps the hold of vector n.

Parameters:
FEAT_BITS, 2, bits per quantized feature.
NUM_FEAT, 4, features per vector; must be >= 2 (elaboration error otherwise).
VEC_W, NUM_FEAT*FEAT_BITS (8), output vector width; derived, not overridable.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
s_valid  in  1  input feature valid.
s_ready  out  1  assembler can accept a feature.
s_data  in  FEAT_BITS  quantized feature value.
s_last  in  1  marks the final feature of a vector.
m_valid  out  1  assembled vector valid.
m_ready  in  1  layer 0 / downstream accepts the vector.
m_data  out  VEC_W  packed vector to layer 0 M0; feature i occupies bits [i*FEAT_BITS +: FEAT_BITS].
frame_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (asynchronous, while rst_n=0): collect buffer, cnt, col_full, m_valid, m_data and frame_err all 0. s_ready=1 once reset is released.
- Collect stage: col buffer (VEC_W), cnt (clog2(NUM_FEAT) bits), col_full flag.
- xfer = col_full && (!m_valid || m_ready). s_ready = !col_full || xfer. This combinational path from m_ready gives full throughput, with no bubble.
- Accept (s_valid && s_ready):
  - Write col[cnt] = s_data.
  - If cnt == NUM_FEAT-1: col_full <= 1, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- Early s_last (s_last=1 on an accepted beat with cnt < NUM_FEAT-1): discard the partial vector, cnt <= 0, col_full unchanged, frame_err pulses next cycle.
- Missing s_last (final beat accepted with s_last=0): vector still completes normally, frame_err pulses next cycle.
- Transfer (xfer): m_data <= col, m_valid <= 1, col_full <= 0.
  - A same-cycle accept of feature 0 for the next vector is legal; col_full then reflects only the new state.
- Output: m_valid clears on m_ready && !xfer. m_data is held stable while m_valid && !m_ready (AXI-style; never changes under backpressure).
- Latency: last feature accepted at edge E0 -> col_full after E0 -> m_valid after E1 if the output slot is free.
- Steady-state throughput: one vector per NUM_FEAT cycles.
- Full condition: col_full && m_valid && !m_ready -> s_ready=0. Input stalls with no loss.
- Reset mid-frame: partial vector and any held output are lost; the next beat after release is feature 0.

Optional Feature:
LOGICNETS_ASM_ERRCNT_EN.
- Defined: adds output err_count [15:0], which counts frame_err pulses, saturates at 16'hFFFF, and is reset to 0 by rst_n.
- Undefined: port absent, no counter logic; frame_err pulse unchanged.

Decomposition:
- Package logicnets_asm_pkg holds FEAT_BITS, NUM_FEAT, VEC_W and CNT_W = clog2(NUM_FEAT) constants, plus typedef feat_t (logic [FEAT_BITS-1:0]) and vec_t (logic [VEC_W-1:0]).
- One sub-module is natural: logicnets_vec_reg, the output valid/ready holding register (m_valid/m_data/xfer logic), reusable between later layers.

Test Plan:
- Basic: beats 2'b01, 2'b10, 2'b11, 2'b00 (s_last on the 4th), m_ready=1 -> m_data=8'h39, m_valid high 2 cycles after the 4th accept, frame_err=0.
- Back-to-back: 3 vectors streamed continuously with m_ready=1 -> s_ready stays 1, one m_valid every 4 cycles, data 8'h39, 8'hE4, 8'h00.
- Backpressure: m_ready=0 after the first vector, stream 2 more vectors ->
  - m_data holds 8'h39.
  - Second vector fills the collect buffer; s_ready=0 on the 9th beat.
  - Raising m_ready drains 8'h39 then the second vector, with no loss.
- Early s_last: s_last on the 2nd beat (01, 10), then 4 beats 11,11,11,11 -> frame_err pulses once, output m_data=8'hFF only.
- Reset mid-frame: rst_n low after 2 beats, release, send 01,10,11,00 -> all outputs 0 during reset, then m_data=8'h39.
- ERRCNT_EN build: 3 early-s_last frames -> err_count=3; without the macro, the design compiles with no err_count port.
